// File: rtl/types_pkg.sv
// Shared types for the rename/dispatch boundary: FU encodings, physical
// register sizing, the renamed-instruction record and the holding-register
// state encoding.
package types_pkg;

  localparam int PREG_COUNT = 128;
  localparam int PREG_W     = 7;
  localparam int FU_W       = 2;

  localparam logic [FU_W-1:0] FU_ALU = 2'd0;
  localparam logic [FU_W-1:0] FU_BR  = 2'd1;
  localparam logic [FU_W-1:0] FU_LSU = 2'd2;

  typedef struct packed {
    logic [FU_W-1:0]   fu;
    logic [6:0]        Opcode;
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [31:0]       imm;
    logic [2:0]        func3;
    logic [6:0]        func7;
  } rename_data;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/preg_ready_table.sv
// Physical-register ready table. One bit per preg: set by writeback, cleared
// when a new destination is allocated (clear wins on a same-cycle collision).
// Preg 0 is hardwired ready. The output bypasses a same-cycle writeback so a
// consumer dispatched alongside its producer's completion sees it ready.
module preg_ready_table
  import types_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [PREG_W-1:0]     set_preg,
  input  logic                  clr_en,
  input  logic [PREG_W-1:0]     clr_preg,
  output logic [0:PREG_COUNT-1] preg_rtable
);

  logic [0:PREG_COUNT-1] rt;
  logic [0:PREG_COUNT-1] rt_next;

  // Next table contents: apply set, then clear so clear takes priority.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    rt_next = rt;
    if (set_en) rt_next[set_preg] = 1'b1;
    if (clr_en) rt_next[clr_preg] = 1'b0;
    rt_next[0] = 1'b1;
  end

  // Table register; the whole table comes out of reset as ready.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: this storage is reset (unlike a data RAM) because "all ready"
    // is architecturally required state after reset, not a don't-care.
    if (reset) begin
      rt <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      rt <= rt_next;
    end
  end

  // Writeback bypass so the stations see a completing producer as ready.
  always_comb begin
    preg_rtable = rt;
    if (set_en) preg_rtable[set_preg] = 1'b1;
  end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch unit: single-entry holding register between rename and the
// reservation stations. Steers the held instruction to the station selected
// by its FU type, allocates a ROB entry in the same cycle, and owns the
// physical-register ready table.
// Optional build macro DISPATCH_STATS_EN adds dispatch/stall counters.
module dispatch_unit
  import types_pkg::*;
#(
  parameter int NUM_RS = 3,
  parameter int STAT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rn_valid,
  input  rename_data            rn_data,
  output logic                  rn_ready,
  input  logic [NUM_RS-1:0]     rs_full,
  output logic [NUM_RS-1:0]     di_en,
  output rename_data            di_data,
  input  logic                  rob_full,
  output logic                  rob_alloc,
  input  logic                  flush,
  input  logic                  wb_valid,
  input  logic [PREG_W-1:0]     wb_preg,
  output logic [0:PREG_COUNT-1] preg_rtable
`ifdef DISPATCH_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_dispatched,
  output logic [STAT_W-1:0]     stat_stall_rs,
  output logic [STAT_W-1:0]     stat_stall_rob
`endif
);

  hold_state_e     state, state_next;
  rename_data      hold_data;
  logic            hold_valid;
  logic [FU_W-1:0] tgt;
  logic            fire;
  logic            accept;

  assign hold_valid = (state == HOLD_FULL);

  // Holding-register state and payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HOLD_EMPTY;
      hold_data <= '0;
    end else begin
      state <= state_next;
      if (accept) hold_data <= rn_data;
    end
  end

  // Steering, handshake and next-state; out-of-range FU types go to ALU.
  always_comb begin
    tgt        = (32'(hold_data.fu) >= NUM_RS) ? FU_ALU : hold_data.fu;
    fire       = hold_valid && !rs_full[tgt] && !rob_full && !flush;
    rn_ready   = !flush && (!hold_valid || fire);
    accept     = rn_valid && rn_ready;
    di_en      = '0;
    di_en[tgt] = fire;
    rob_alloc  = fire;
    di_data    = hold_data;
    state_next = state;
    if (flush)       state_next = HOLD_EMPTY;
    else if (accept) state_next = HOLD_FULL;
    else if (fire)   state_next = HOLD_EMPTY;
  end

  preg_ready_table u_rtable (
    .clk         (clk),
    .reset       (reset),
    .set_en      (wb_valid),
    .set_preg    (wb_preg),
    .clr_en      (fire && (hold_data.pd_new != '0)),
    .clr_preg    (hold_data.pd_new),
    .preg_rtable (preg_rtable)
  );

`ifdef DISPATCH_STATS_EN
  // Free-running wrap-around counters for dispatches and stall causes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_dispatched <= '0;
      stat_stall_rs   <= '0;
      stat_stall_rob  <= '0;
    end else begin
      if (fire)
        stat_dispatched <= stat_dispatched + 1'b1;
      if (hold_valid && rs_full[tgt] && !flush)
        stat_stall_rs <= stat_stall_rs + 1'b1;
      if (hold_valid && rob_full && !flush)
        stat_stall_rob <= stat_stall_rob + 1'b1;
    end
  end
`endif

endmodule

// File: doc/dispatch_unit.md
Name: dispatch_unit

Overview:
- Producer side of the reservation-station dispatch interface.
- Takes renamed instructions from rename through a valid/ready handshake and holds one in a single-entry holding register.
- Steers each instruction to one reservation station by FU type, asserting that station's di_en, and allocates a ROB entry on the same cycle.
- Owns the physical-register ready table (preg_rtable) that the stations sample at dispatch; the table is cleared on destination allocation and set on writeback broadcast.

Parameters:
NUM_RS, 3, number of reservation stations (index = FU type: 0 ALU, 1 branch, 2 LSU)
PREG_COUNT, 128, physical registers; preg index width 7
STAT_W, 32, counter width (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  reset
rn_valid  in  1  rename has an instruction
rn_data  in  rename_data  renamed instruction (fu, Opcode, pd_new, ps1, ps2, imm, func3, func7)
rn_ready  out  1  dispatch can accept rn_data this cycle
rs_full  in  NUM_RS  per-station full flag
di_en  out  NUM_RS  one-hot write enable to the target station
di_data  out  rename_data  held instruction, fanned out to all stations
rob_full  in  1  ROB cannot allocate
rob_alloc  out  1  ROB allocate strobe; equals |di_en
flush  in  1  mispredict squash
wb_valid  in  1  FU completion broadcast
wb_preg  in  7  completing physical register
preg_rtable  out  [0:PREG_COUNT-1]  ready bit per preg, with writeback bypass

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clk is the clock.
- State: hold_valid (EMPTY/FULL), hold_data.
- Target selection:
  - tgt = hold_data.fu.
  - fu >= NUM_RS routes to station 0.
- fire = hold_valid && !rs_full[tgt] && !rob_full && !flush.
- Outputs:
  - di_en[tgt] = fire, all other di_en bits 0; combinational.
  - rob_alloc = fire.
  - di_data = hold_data.
- Handshake:
  - rn_ready = !flush && (!hold_valid || fire).
  - On rn_valid && rn_ready, hold_data <= rn_data and hold_valid <= 1.
  - Else on fire, hold_valid <= 0.
  - Back-to-back dispatch gives 1 instruction/cycle; latency is 1 cycle from rename accept to di_en.
- Stall: when the target station is full or the ROB is full, hold_data stays stable and rn_ready = 0.
- flush:
  - hold_valid <= 0 next edge; no di_en or rob_alloc that cycle.
  - An rn_valid in the flush cycle is not accepted.
  - preg_rtable is not modified.
- Ready table (registered, rt[]):
  - Reset: all 1.
  - wb_valid sets rt[wb_preg].
  - fire with hold_data.pd_new != 0 clears rt[pd_new].
  - Same preg set and cleared in one cycle: clear wins.
  - rt[0] is always 1; writes to it are ignored.
- Bypass: preg_rtable[i] = rt[i] | (wb_valid && wb_preg == i). A producer completing in the dispatch cycle is therefore seen ready by the station.
- Reset mid-operation: hold_valid = 0, di_en = 0, rob_alloc = 0, rn_ready = 1 while reset is deasserted and flush is 0; table all 1.

Optional Feature:
- Macro: DISPATCH_STATS_EN.
- Defined:
  - Adds outputs stat_dispatched (STAT_W), incremented on each fire.
  - Adds stat_stall_rs (STAT_W), incremented each cycle hold_valid && rs_full[tgt] && !flush.
  - Adds stat_stall_rob (STAT_W), incremented each cycle hold_valid && rob_full && !flush.
  - All three reset to 0 and wrap at 2^STAT_W.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- types_pkg:
  - FU encoding constants FU_ALU = 0, FU_BR = 1, FU_LSU = 2.
  - PREG_COUNT and PREG_W = 7.
  - rename_data already lives there.
- One sub-module, preg_ready_table: set port, clear port, clear-wins priority, p0 hardwire, bypass output. The dispatch_unit top holds the handshake and steering logic.

Test Plan:
- Reset, then rn_valid with fu = 0, pd_new = 40 → next cycle di_en = 3'b001 and rob_alloc = 1; cycle after, preg_rtable[40] = 0.
- fu = 2 with rs_full = 3'b100 for 3 cycles → di_en = 0, rn_ready = 0, di_data stable; on release, di_en = 3'b100 in the same cycle.
- wb_valid with wb_preg = 40 while dispatching an instruction with ps1 = 40 → preg_rtable[40] = 1 combinationally that cycle, and rt[40] = 1 after.
- Same-cycle fire with pd_new = 50 and wb_preg = 50 → rt[50] = 0; fire with pd_new = 0 → rt[0] stays 1.
- flush while holding a stalled instruction with rn_valid = 1 → no di_en, rn_ready = 0, hold empty next cycle; next rn_valid accepted normally.
- Streaming 8 ALU ops with no stalls → di_en asserted 8 consecutive cycles and, with DISPATCH_STATS_EN, stat_dispatched = 8.
